// File: rtl/tc_io_pin_ctrl_if.sv
// rtl/tc_io_pin_ctrl_if.sv - register bus interface for tc_io_pin_ctrl
//
// Purpose: groups the single-cycle register bus between a bus master and
//          the pin controller.
// Signals:
//    reg_wr_i     write strobe, one cycle
//    reg_rd_i     read strobe, one cycle
//    reg_addr_i   word address
//    reg_wdata_i  write data
//    reg_rdata_o  read data, zero unless reg_rvalid_o
//    reg_rvalid_o read-data valid pulse, one cycle after reg_rd_i
interface tc_io_pin_ctrl_if;
   logic        reg_wr_i;
   logic        reg_rd_i;
   logic [3:0]  reg_addr_i;
   logic [31:0] reg_wdata_i;
   logic [31:0] reg_rdata_o;
   logic        reg_rvalid_o;

   modport master (
      output reg_wr_i, reg_rd_i, reg_addr_i, reg_wdata_i,
      input  reg_rdata_o, reg_rvalid_o
   );

   modport slave (
      input  reg_wr_i, reg_rd_i, reg_addr_i, reg_wdata_i,
      output reg_rdata_o, reg_rvalid_o
   );
endinterface

// File: rtl/tc_io_pin_ctrl.sv
// rtl/tc_io_pin_ctrl.sv - core-side controller for a bank of tri-state pads
//
// Purpose: register file driving pad output value, enable, Schmitt select
//          and pulls; samples pad inputs through a 2-flop synchronizer and
//          a per-pin debouncer; flags debounced edges in ISTAT and raises irq_o.
// Ports:
//    clk_i        system clock
//    rst_i        asynchronous active-high reset
//    bus          register bus (slave side)
//    pad_c2p_o    core-to-pad output values (OUT)
//    pad_c2p_en_o output enables, 1 = drive (OE)
//    pad_cs_o     input type, 1 = CMOS, 0 = Schmitt (CS)
//    pad_pu_o     pull-up enables (PU)
//    pad_pd_o     pull-down enables (PD)
//    pad_p2c_i    asynchronous pad-to-core inputs
//    irq_o        level interrupt, OR of ISTAT delayed by one flop
module tc_io_pin_ctrl #(
   parameter int NUM_PINS = 8,
   parameter int DBNC_W   = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   tc_io_pin_ctrl_if.slave     bus,
   output logic [NUM_PINS-1:0] pad_c2p_o,
   output logic [NUM_PINS-1:0] pad_c2p_en_o,
   output logic [NUM_PINS-1:0] pad_cs_o,
   output logic [NUM_PINS-1:0] pad_pu_o,
   output logic [NUM_PINS-1:0] pad_pd_o,
   input  logic [NUM_PINS-1:0] pad_p2c_i,
   output logic                irq_o
);

   localparam logic [3:0] ADDR_OUT     = 4'd0;
   localparam logic [3:0] ADDR_OE      = 4'd1;
   localparam logic [3:0] ADDR_CS      = 4'd2;
   localparam logic [3:0] ADDR_PU      = 4'd3;
   localparam logic [3:0] ADDR_PD      = 4'd4;
   localparam logic [3:0] ADDR_IN      = 4'd5;
   localparam logic [3:0] ADDR_DBNC    = 4'd6;
   localparam logic [3:0] ADDR_RISE_IE = 4'd7;
   localparam logic [3:0] ADDR_FALL_IE = 4'd8;
   localparam logic [3:0] ADDR_ISTAT   = 4'd9;

   logic [NUM_PINS-1:0] out_q, oe_q, cs_q, pu_q, pd_q;
   logic [NUM_PINS-1:0] rise_ie_q, fall_ie_q, istat_q;
   logic [DBNC_W-1:0]   dbnc_q;
   logic [NUM_PINS-1:0] sync1_q, sync2_q, deb_q;
   logic [DBNC_W-1:0]   cnt_q [NUM_PINS];
   logic [NUM_PINS-1:0] accept, edge_set, w1c_clr, wpins;
   logic [31:0]         rd_mux, rdata_q;
   logic                rvalid_q, irq_q;
   logic                unused_wdata;

   assign wpins        = bus.reg_wdata_i[NUM_PINS-1:0];
   assign unused_wdata = ^bus.reg_wdata_i;

   // A pin is accepted when the synchronized value has disagreed with deb
   // and the run counter has reached the threshold; the counter wraps, so a
   // threshold lowered below the running count is reached after wrap-around.
   always_comb begin
      accept = '0;
      for (int i = 0; i < NUM_PINS; i++) begin
         accept[i] = (sync2_q[i] != deb_q[i]) && (cnt_q[i] == dbnc_q);
      end
   end

   // Direction of the accepted edge is the new value sync2_q carries.
   assign edge_set = accept & ((sync2_q & rise_ie_q) | (~sync2_q & fall_ie_q));
   assign w1c_clr  = (bus.reg_wr_i && (bus.reg_addr_i == ADDR_ISTAT)) ? wpins : '0;

   always_comb begin
      rd_mux = '0;
      case (bus.reg_addr_i)
         ADDR_OUT:     rd_mux[NUM_PINS-1:0] = out_q;
         ADDR_OE:      rd_mux[NUM_PINS-1:0] = oe_q;
         ADDR_CS:      rd_mux[NUM_PINS-1:0] = cs_q;
         ADDR_PU:      rd_mux[NUM_PINS-1:0] = pu_q;
         ADDR_PD:      rd_mux[NUM_PINS-1:0] = pd_q;
         ADDR_IN:      rd_mux[NUM_PINS-1:0] = deb_q;
         ADDR_DBNC:    rd_mux[DBNC_W-1:0]   = dbnc_q;
         ADDR_RISE_IE: rd_mux[NUM_PINS-1:0] = rise_ie_q;
         ADDR_FALL_IE: rd_mux[NUM_PINS-1:0] = fall_ie_q;
         ADDR_ISTAT:   rd_mux[NUM_PINS-1:0] = istat_q;
         default:      rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_q     <= '0;
         oe_q      <= '0;
         cs_q      <= '1;
         pu_q      <= '0;
         pd_q      <= '0;
         dbnc_q    <= '0;
         rise_ie_q <= '0;
         fall_ie_q <= '0;
         istat_q   <= '0;
         irq_q     <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         if (bus.reg_wr_i) begin
            case (bus.reg_addr_i)
               ADDR_OUT:     out_q     <= wpins;
               ADDR_OE:      oe_q      <= wpins;
               ADDR_CS:      cs_q      <= wpins;
               ADDR_PU:      pu_q      <= wpins;
               ADDR_PD:      pd_q      <= wpins;
               ADDR_DBNC:    dbnc_q    <= bus.reg_wdata_i[DBNC_W-1:0];
               ADDR_RISE_IE: rise_ie_q <= wpins;
               ADDR_FALL_IE: fall_ie_q <= wpins;
               default:      ;
            endcase
         end
         // Set is applied after clear so a simultaneous edge wins.
         istat_q  <= (istat_q & ~w1c_clr) | edge_set;
         // Registered OR keeps irq_o free of decode glitches.
         irq_q    <= |istat_q;
         rvalid_q <= bus.reg_rd_i;
         rdata_q  <= bus.reg_rd_i ? rd_mux : '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
         deb_q   <= '0;
         for (int i = 0; i < NUM_PINS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= pad_p2c_i;
         sync2_q <= sync1_q;
         for (int i = 0; i < NUM_PINS; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
               cnt_q[i] <= '0;
            end else if (accept[i]) begin
               deb_q[i] <= sync2_q[i];
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + DBNC_W'(1);
            end
         end
      end
   end

   assign pad_c2p_o        = out_q;
   assign pad_c2p_en_o     = oe_q;
   assign pad_cs_o         = cs_q;
   assign pad_pu_o         = pu_q;
   assign pad_pd_o         = pd_q;
   assign irq_o            = irq_q;
   assign bus.reg_rdata_o  = rdata_q;
   assign bus.reg_rvalid_o = rvalid_q;

endmodule
